// File: rtl/sva_thread_sched_if.sv
// sva_thread_sched_if: request/response handshake between the thread scheduler and the next-state evaluator.
interface sva_thread_sched_if #(parameter int STATE_W = 8);
    logic               req_vld;
    logic               req_rdy;
    logic [STATE_W-1:0] req_state;
    logic               rsp_vld;
    logic               rsp_active;
    logic [STATE_W-1:0] rsp_state;
    logic               rsp_succ;
    logic               rsp_fail;
    modport master (output req_vld, req_state, input req_rdy, rsp_vld, rsp_active, rsp_state, rsp_succ, rsp_fail);
    modport slave (input req_vld, req_state, output req_rdy, rsp_vld, rsp_active, rsp_state, rsp_succ, rsp_fail);
endinterface

// File: rtl/sva_thread_sched.sv
// sva_thread_sched: per-tick walk of live assertion threads through the evaluator, in-place compaction, one spawn per round.
module sva_thread_sched #(
    parameter int SLOT_NUM   = 4,
    parameter int STATE_W    = 8,
    parameter int INIT_STATE = 0,
    parameter int TIMER_W    = 8,
    localparam int IDX_W     = $clog2(SLOT_NUM + 1)
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                flush,
    input  logic                tick,
    sva_thread_sched_if.master  eval,
    output logic                busy,
    output logic                round_done,
    output logic [IDX_W-1:0]    live_cnt,
    output logic [15:0]         succ_cnt,
    output logic [15:0]         fail_cnt,
    output logic [TIMER_W-1:0]  succ_age,
    output logic                overflow,
    output logic                tick_miss
);
    localparam int DEPTH = 1 << IDX_W;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMMIT} state_t;
    state_t state_q, state_d;
    logic [IDX_W-1:0] rd_idx, wr_idx, rd_nxt;
    logic spawn_phase, rsp_fire, room, slot_wr;
    logic [TIMER_W-1:0] round_id, cur_start;
    logic [STATE_W-1:0] slot_state [DEPTH];
    logic [TIMER_W-1:0] slot_start [DEPTH];

    assign rsp_fire = state_q == WAIT && eval.rsp_vld;
    assign room = wr_idx != IDX_W'(SLOT_NUM);
    assign slot_wr = rsp_fire && eval.rsp_active && room;
    assign rd_nxt = rd_idx + IDX_W'(1);
    assign cur_start = spawn_phase ? round_id : slot_start[rd_idx];
    assign eval.req_vld = state_q == ISSUE;
    assign eval.req_state = spawn_phase ? STATE_W'(INIT_STATE) : slot_state[rd_idx];
    assign busy = state_q != IDLE;
    assign round_done = state_q == COMMIT;
    assign overflow = rsp_fire && eval.rsp_active && spawn_phase && !room;
    assign tick_miss = tick && busy && !flush;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   state_d = tick ? ISSUE : IDLE;
            ISSUE:  state_d = eval.req_rdy ? WAIT : ISSUE;
            WAIT:   state_d = !eval.rsp_vld ? WAIT : spawn_phase ? COMMIT : ISSUE;
            COMMIT: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            rd_idx      <= '0;
            wr_idx      <= '0;
            spawn_phase <= 1'b0;
            round_id    <= '0;
            live_cnt    <= '0;
            succ_cnt    <= '0;
            fail_cnt    <= '0;
            succ_age    <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                round_id    <= '0;
                live_cnt    <= '0;
                rd_idx      <= '0;
                wr_idx      <= '0;
                spawn_phase <= 1'b0;
            end else begin
                if (state_q == IDLE && tick) begin
                    round_id    <= round_id + TIMER_W'(1);
                    rd_idx      <= '0;
                    wr_idx      <= '0;
                    spawn_phase <= live_cnt == '0;
                end
                if (rsp_fire) begin
                    if (slot_wr) wr_idx <= wr_idx + IDX_W'(1);
                    if (eval.rsp_succ) begin
                        succ_cnt <= succ_cnt + 16'(!(&succ_cnt));
                        succ_age <= round_id - cur_start;
                    end
                    if (eval.rsp_fail) fail_cnt <= fail_cnt + 16'(!(&fail_cnt));
                    if (!spawn_phase) begin
                        rd_idx      <= rd_nxt;
                        spawn_phase <= rd_nxt == live_cnt;
                    end
                end
                if (state_q == COMMIT) live_cnt <= wr_idx;
            end
        end
    end

    // Survivors land at wr_idx <= rd_idx, so a slot is only overwritten after it has been read.
    always_ff @(posedge sys_clk) begin
        if (slot_wr) begin
            slot_state[wr_idx] <= eval.rsp_state;
            slot_start[wr_idx] <= cur_start;
        end
    end
endmodule
